// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: cache read port A, redirect request and decode-side FIFO head.
// The master modport is the fetch unit; the slave modport is the cache/decode environment.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              valid_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] dataout_a;
  logic              ready_a;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output valid_a, addr_a, inst_valid, inst, inst_pc,
    input  dataout_a, ready_a, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  valid_a, addr_a, inst_valid, inst, inst_pc,
    output dataout_a, ready_a, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generator, single-outstanding cache reads, prefetch FIFO, redirect squash.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);

  localparam int                INC        = DATA_W / 8;
  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam int                ENT_W      = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] INC_A      = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(INC_A - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  FULL       = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]  fifo_q [DEPTH];

  logic              push;
  logic              pop;
  logic              flush;
  logic [ADDR_W-1:0] target;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  assign target = align_pc(bus.redirect_pc);
  assign flush  = bus.redirect_valid;
  // A completing read is only queued when it was not squashed in this same cycle.
  assign push   = (state_q == REQ) && bus.ready_a && !bus.redirect_valid;
  assign pop    = (count_q != '0) && bus.inst_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          pc_d    = target;
          state_d = REQ;
        end else if (count_d < FULL) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          if (bus.ready_a) begin
            pc_d    = target;
            state_d = REQ;
          end else begin
            // Read still outstanding: keep addr_a stable, park the target.
            pend_d  = target;
            state_d = DISCARD;
          end
        end else if (bus.ready_a) begin
          pc_d    = pc_q + INC_A;
          state_d = (count_d < FULL) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (bus.ready_a) begin
          pc_d    = bus.redirect_valid ? target : pend_q;
          state_d = REQ;
        end else if (bus.redirect_valid) begin
          pend_d  = target;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data-only; occupancy is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {pc_q, bus.dataout_a};
    end
  end

  assign bus.valid_a               = (state_q != IDLE);
  assign bus.addr_a                = pc_q;
  assign bus.inst_valid            = (count_q != '0);
  assign {bus.inst_pc, bus.inst}   = fifo_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if ((state_q == IDLE) && (count_q == FULL)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q != IDLE) && !bus.ready_a) |=> ((state_q != IDLE) && $stable(pc_q)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q != FULL));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int                ADDR_W   = 16;
  localparam int                DATA_W   = 32;
  localparam int                DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache contents: each word encodes its own address.
  function automatic logic [31:0] word(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] w;
  } ent_t;

  // Reference model: the outstanding read, whether it is squashed, and the FIFO as a queue.
  ent_t        q[$];
  bit          m_busy;
  bit          m_squash;
  logic [15:0] m_pc;
  logic [15:0] m_pend;
  int unsigned m_fetched;
  int unsigned m_stall;

  // Stimulus controls.
  int          lat_min = 0, lat_max = 0, cur_lat = 0, wait_cnt = 0;
  int          ir_pct = 100, rd_pct = 0, rd_mode = 0;
  bit          noise_en = 0, rd_fired = 0;
  logic [15:0] rd_trig = '0, rd_target = '0;
  logic [15:0] hs_log[$];
  ent_t        pop_log[$];

  task automatic model_reset();
    q.delete();
    m_busy    = 0;
    m_squash  = 0;
    m_pc      = RESET_PC;
    m_pend    = RESET_PC;
    m_fetched = 0;
    m_stall   = 0;
  endtask

  function automatic logic [15:0] rand_target();
    case ($urandom_range(3, 0))
      0, 1:    return 16'($urandom);
      2:       return 16'hFFF0 | 16'($urandom_range(15, 0));
      default: return 16'($urandom_range(255, 0));
    endcase
  endfunction

  task automatic compare();
    chk("valid_a", bus.valid_a, m_busy);
    chk("addr_a", bus.addr_a, m_pc);
    chk("inst_valid", bus.inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("inst", bus.inst, q[0].w);
      chk("inst_pc", bus.inst_pc, q[0].pc);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
  endtask

  task automatic drive();
    if (bus.valid_a) begin
      if (wait_cnt >= cur_lat) begin
        bus.ready_a   = 1'b1;
        bus.dataout_a = word(bus.addr_a);
        wait_cnt      = 0;
        cur_lat       = int'($urandom_range(lat_max, lat_min));
      end else begin
        bus.ready_a   = 1'b0;
        bus.dataout_a = $urandom;
        wait_cnt++;
      end
    end else begin
      wait_cnt      = 0;
      bus.ready_a   = noise_en && ($urandom_range(3, 0) == 0);
      bus.dataout_a = $urandom;
    end
    bus.inst_ready     = ($urandom_range(99, 0) < ir_pct);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'($urandom);
    if (rd_mode == 1) begin
      if ($urandom_range(99, 0) < rd_pct) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = rand_target();
      end
    end else if (rd_mode == 2 || rd_mode == 3) begin
      if (bus.valid_a && bus.addr_a == rd_trig && (bus.ready_a == (rd_mode == 2))) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = rd_target;
        rd_fired           = 1;
        rd_mode            = 0;
      end
    end
    if (bus.valid_a && bus.ready_a) hs_log.push_back(bus.addr_a);
    if (bus.inst_valid && bus.inst_ready) pop_log.push_back({bus.inst_pc, bus.inst});
  endtask

  // Predict the state after the coming rising edge from the inputs just driven.
  task automatic model_update();
    bit          rv, comp;
    logic [15:0] tgt;
    rv   = bus.redirect_valid;
    tgt  = bus.redirect_pc & 16'hFFFC;
    comp = m_busy && bus.ready_a;
    if (!m_busy && q.size() == DEPTH) m_stall++;
    if (q.size() != 0 && bus.inst_ready) void'(q.pop_front());
    if (rv) begin
      q.delete();
      if (!m_busy || comp) begin
        m_busy   = 1;
        m_pc     = tgt;
        m_squash = 0;
      end else begin
        m_squash = 1;
        m_pend   = tgt;
      end
    end else if (comp) begin
      if (m_squash) begin
        m_pc     = m_pend;
        m_squash = 0;
        m_busy   = 1;
      end else begin
        q.push_back('{pc: m_pc, w: word(m_pc)});
        m_fetched++;
        m_pc   = m_pc + 16'd4;
        m_busy = (q.size() < DEPTH);
      end
    end else if (!m_busy) begin
      m_busy = (q.size() < DEPTH);
    end
  endtask

  task automatic body();
    compare();
    drive();
    model_update();
  endtask

  task automatic cycle();
    @(negedge clk);
    body();
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ready_a        = 1'b0;
    bus.dataout_a      = '0;
    bus.inst_ready     = 1'b0;
    #1;
    chk("rst_valid_a", bus.valid_a, 1'b0);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_addr_a", bus.addr_a, RESET_PC);
    model_reset();
    wait_cnt = 0;
    cur_lat  = lat_min;
    rd_fired = 0;
    hs_log.delete();
    pop_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    body();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_addr [4];
    logic [31:0] exp_word [4];
    int          n8;
    exp_addr = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
    exp_word = '{32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008, 32'hC0DE000C};

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ready_a        = 1'b0;
    bus.dataout_a      = '0;
    bus.inst_ready     = 1'b0;
    #1;

    // Sequential fetch, cache answers two cycles after each request.
    lat_min = 2; lat_max = 2; ir_pct = 100; rd_mode = 0; noise_en = 0;
    do_reset();
    repeat (25) cycle();
    chk("A_hs_count_ge4", hs_log.size() >= 4, 1'b1);
    chk("A_pop_count_ge4", pop_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (hs_log.size() > i) chk("A_addr_seq", hs_log[i], exp_addr[i]);
      if (pop_log.size() > i) begin
        chk("A_inst_pc", pop_log[i].pc, exp_addr[i]);
        chk("A_inst", pop_log[i].w, exp_word[i]);
      end
    end

    // Decode stalled: FIFO fills with exactly DEPTH words, then one pop restarts fetch.
    lat_min = 0; lat_max = 0; ir_pct = 0;
    do_reset();
    repeat (12) cycle();
    chk("B_pushes", hs_log.size(), 4);
    chk("B_valid_a_idle", bus.valid_a, 1'b0);
    chk("B_inst_valid", bus.inst_valid, 1'b1);
`ifdef FETCH_PERF_EN
    chk("B_perf_fetched", perf_fetched, 32'd4);
`endif
    ir_pct = 100;
    cycle();
    ir_pct = 0;
    cycle();
    chk("B_refetch_valid", bus.valid_a, 1'b1);
    chk("B_refetch_addr", bus.addr_a, 16'h0010);

    // Redirect while the read to 0x0008 is still pending.
    lat_min = 3; lat_max = 3; ir_pct = 100;
    do_reset();
    rd_mode = 3; rd_trig = 16'h0008; rd_target = 16'h0102;
    for (int i = 0; i < 60 && !rd_fired; i++) cycle();
    chk("C_fired", rd_fired, 1'b1);
    cycle();
    chk("C_hold_valid", bus.valid_a, 1'b1);
    chk("C_hold_addr", bus.addr_a, 16'h0008);
    chk("C_flushed", bus.inst_valid, 1'b0);
    for (int i = 0; i < 20 && bus.addr_a == 16'h0008; i++) cycle();
    chk("C_new_addr", bus.addr_a, 16'h0100);
    n8 = 0;
    foreach (pop_log[i]) if (pop_log[i].pc == 16'h0008) n8++;
    chk("C_no_0008_word", n8, 0);

    // Redirect coinciding with completion of the 0x0004 read.
    lat_min = 1; lat_max = 1; ir_pct = 100;
    do_reset();
    rd_mode = 2; rd_trig = 16'h0004; rd_target = 16'h0200;
    for (int i = 0; i < 60 && !rd_fired; i++) cycle();
    chk("D_fired", rd_fired, 1'b1);
    cycle();
    chk("D_valid", bus.valid_a, 1'b1);
    chk("D_addr", bus.addr_a, 16'h0200);
    chk("D_flushed", bus.inst_valid, 1'b0);
    for (int i = 0; i < 20 && !bus.inst_valid; i++) cycle();
    chk("D_head_pc", bus.inst_pc, 16'h0200);
    chk("D_head_word", bus.inst, 32'hC0DE0200);

    // Asynchronous reset while a request is outstanding and the FIFO holds data.
    lat_min = 0; lat_max = 0; ir_pct = 0;
    do_reset();
    repeat (3) cycle();
    chk("E_pre_valid_a", bus.valid_a, 1'b1);
    chk("E_pre_inst_valid", bus.inst_valid, 1'b1);
    #2;
    do_reset();

    // Randomized segments: latency, decode back-pressure, redirect rate, idle noise on ready_a.
    noise_en = 1;
    for (int seg = 0; seg < 6; seg++) begin
      lat_min = (seg % 3 == 0) ? 0 : 1;
      lat_max = lat_min + (seg % 4);
      ir_pct  = (seg % 2 == 0) ? 25 : 80;
      rd_pct  = (seg < 3) ? 4 : 15;
      rd_mode = 1;
      repeat (500) cycle();
      if (seg == 2) begin
        #2;
        do_reset();
        rd_mode = 1;
      end
    end
    rd_mode = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
